mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit_if.sv | 26 ++
 rtl/mult_div_unit.sv | 132 +++++++++++++
 tb/tb_mult_div_unit.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_if.sv
// Operand, result and handshake bundle for the iterative multiply/divide unit.
// The master drives operands and MTHI/MTLO strobes; the slave returns HI/LO and status.
interface mult_div_unit_if #(parameter int WL = 32);
   logic          start;
   logic [1:0]    op;
   logic [WL-1:0] A;
   logic [WL-1:0] B;
   logic          wr_hi;
   logic          wr_lo;
   logic [WL-1:0] wdata;
   logic [WL-1:0] hi;
   logic [WL-1:0] lo;
   logic          busy;
   logic          done;
   logic          div_by_zero;

   modport master (
      output start, op, A, B, wr_hi, wr_lo, wdata,
      input  hi, lo, busy, done, div_by_zero
   );

   modport slave (
      input  start, op, A, B, wr_hi, wr_lo, wdata,
      output hi, lo, busy, done, div_by_zero
   );
endinterface

// File: rtl/mult_div_unit.sv
// MIPS-style HI/LO multiply/divide: shift-add multiply, restoring divide, one bit per cycle.
// Result lands 33 cycles after start is accepted; start and MTHI/MTLO are ignored while busy.
module mult_div_unit #(
   parameter int WL = 32
) (
   input logic            clk,
   input logic            rst,
   mult_div_unit_if.slave bus
);
   localparam int CW = $clog2(WL);
   localparam logic [CW-1:0] LAST = CW'(WL - 1);

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t          r_state;
   state_t          w_next;
   logic [CW-1:0]   r_cnt;
   logic [2*WL-1:0] r_acc;
   logic [WL-1:0]   r_bm;
   logic [WL-1:0]   r_hi;
   logic [WL-1:0]   r_lo;
   logic            r_div;
   logic            r_neg;
   logic            r_sa;
   logic            r_bzero;
   logic            r_done;
   logic            r_dbz;

   logic            w_sa;
   logic            w_sb;
   logic [WL-1:0]   w_am;
   logic [WL-1:0]   w_bm;
   logic [WL:0]     w_mul_sum;
   logic [2*WL-1:0] w_mul_next;
   logic [2*WL:0]   w_shift;
   logic [WL:0]     w_trial;
   logic [2*WL-1:0] w_div_next;
   logic [2*WL-1:0] w_prod;
   logic [WL-1:0]   w_quo;
   logic [WL-1:0]   w_rem;

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (bus.start) w_next = RUN;
         RUN:     if (r_cnt == LAST) w_next = FIN;
         FIN:     w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Signed ops work on magnitudes; signs are reapplied once in FIN.
   always_comb begin
      w_sa = bus.op[0] & bus.A[WL-1];
      w_sb = bus.op[0] & bus.B[WL-1];
      w_am = w_sa ? -bus.A : bus.A;
      w_bm = w_sb ? -bus.B : bus.B;

      w_mul_sum  = {1'b0, r_acc[2*WL-1:WL]} + (r_acc[0] ? {1'b0, r_bm} : {(WL+1){1'b0}});
      w_mul_next = {w_mul_sum, r_acc[WL-1:1]};

      w_shift    = {r_acc, 1'b0};
      w_trial    = w_shift[2*WL:WL] - {1'b0, r_bm};
      w_div_next = w_trial[WL] ? w_shift[2*WL-1:0]
                               : {w_trial[WL-1:0], w_shift[WL-1:1], 1'b1};

      w_prod = r_neg ? -r_acc : r_acc;
      // With a zero divisor the remainder already equals |A|, so only the quotient needs forcing.
      w_quo  = r_bzero ? {WL{1'b1}} : (r_neg ? -r_acc[WL-1:0] : r_acc[WL-1:0]);
      w_rem  = r_sa ? -r_acc[2*WL-1:WL] : r_acc[2*WL-1:WL];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt   <= '0;
         r_acc   <= '0;
         r_bm    <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_div   <= 1'b0;
         r_neg   <= 1'b0;
         r_sa    <= 1'b0;
         r_bzero <= 1'b0;
         r_done  <= 1'b0;
         r_dbz   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_dbz  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.wr_hi) r_hi <= bus.wdata;
               if (bus.wr_lo) r_lo <= bus.wdata;
               if (bus.start) begin
                  r_div   <= bus.op[1];
                  r_neg   <= w_sa ^ w_sb;
                  r_sa    <= w_sa;
                  r_bzero <= (bus.B == '0);
                  r_bm    <= w_bm;
                  r_acc   <= {{WL{1'b0}}, w_am};
                  r_cnt   <= '0;
               end
            end
            RUN: begin
               r_acc <= r_div ? w_div_next : w_mul_next;
               r_cnt <= r_cnt + CW'(1);
            end
            FIN: begin
               if (r_div) begin
                  r_lo  <= w_quo;
                  r_hi  <= w_rem;
                  r_dbz <= r_bzero;
               end else begin
                  {r_hi, r_lo} <= w_prod;
               end
               r_done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.hi          = r_hi;
   assign bus.lo          = r_lo;
   assign bus.busy        = (r_state != IDLE);
   assign bus.done        = r_done;
   assign bus.div_by_zero = r_dbz;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: hand-computed HI/LO results, latency, abort and strobe gating.
module tb_mult_div_unit;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   mult_div_unit_if #(.WL(32)) bus ();

   mult_div_unit #(.WL(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.op    = op;
      bus.A     = a;
      bus.B     = b;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   task automatic wait_done(output int cycles, output logic dbz);
      cycles = 0;
      dbz    = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk);
         #1;
         cycles++;
         if (bus.done) begin
            dbz = bus.div_by_zero;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      bus.wr_hi = 1'b1;
      bus.wdata = 32'hA5A5_A5A5;
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (bus.hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h want 00000000", bus.hi); end
      bus.wr_hi = 1'b0;
      rst       = 1'b0;
      n_checks++; if (bus.lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h want 00000000", bus.lo); end
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
      n_checks++; if (bus.div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dbz: got %b want 0", bus.div_by_zero); end
   endtask

   task automatic test_multu();
      int cyc; logic dbz;
      start_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL multu_busy_start: got %b want 1", bus.busy); end
      wait_done(cyc, dbz);
      n_checks++; if (cyc !== 33) begin n_fail++; $display("FAIL multu_latency: got %0d want 33", cyc); end
      n_checks++; if (bus.hi !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_hi: got %h want fffffffe", bus.hi); end
      n_checks++; if (bus.lo !== 32'h0000_0001) begin n_fail++; $display("FAIL multu_lo: got %h want 00000001", bus.lo); end
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL multu_busy_done: got %b want 0", bus.busy); end
   endtask

   task automatic test_mult();
      int cyc; logic dbz;
      start_op(2'b01, 32'hFFFF_FFFD, 32'd5);
      wait_done(cyc, dbz);
      n_checks++; if (cyc !== 33) begin n_fail++; $display("FAIL mult_latency: got %0d want 33", cyc); end
      n_checks++; if (bus.hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_hi: got %h want ffffffff", bus.hi); end
      n_checks++; if (bus.lo !== 32'hFFFF_FFF1) begin n_fail++; $display("FAIL mult_lo: got %h want fffffff1", bus.lo); end
   endtask

   task automatic test_div();
      int cyc; logic dbz;
      start_op(2'b11, 32'hFFFF_FFF9, 32'd2);
      wait_done(cyc, dbz);
      n_checks++; if (cyc !== 33) begin n_fail++; $display("FAIL div_latency: got %0d want 33", cyc); end
      n_checks++; if (bus.lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_neg_lo: got %h want fffffffd", bus.lo); end
      n_checks++; if (bus.hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_neg_hi: got %h want ffffffff", bus.hi); end
      n_checks++; if (dbz !== 1'b0) begin n_fail++; $display("FAIL div_neg_dbz: got %b want 0", dbz); end
      start_op(2'b11, 32'd7, 32'hFFFF_FFFE);
      wait_done(cyc, dbz);
      n_checks++; if (bus.lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_negb_lo: got %h want fffffffd", bus.lo); end
      n_checks++; if (bus.hi !== 32'h0000_0001) begin n_fail++; $display("FAIL div_negb_hi: got %h want 00000001", bus.hi); end
      start_op(2'b10, 32'd100, 32'd7);
      wait_done(cyc, dbz);
      n_checks++; if (bus.lo !== 32'd14) begin n_fail++; $display("FAIL divu_lo: got %h want 0000000e", bus.lo); end
      n_checks++; if (bus.hi !== 32'd2) begin n_fail++; $display("FAIL divu_hi: got %h want 00000002", bus.hi); end
   endtask

   task automatic test_div_by_zero();
      int cyc; logic dbz;
      start_op(2'b10, 32'd100, 32'd0);
      wait_done(cyc, dbz);
      n_checks++; if (cyc !== 33) begin n_fail++; $display("FAIL dbz_latency: got %0d want 33", cyc); end
      n_checks++; if (bus.lo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL dbz_lo: got %h want ffffffff", bus.lo); end
      n_checks++; if (bus.hi !== 32'h0000_0064) begin n_fail++; $display("FAIL dbz_hi: got %h want 00000064", bus.hi); end
      n_checks++; if (dbz !== 1'b1) begin n_fail++; $display("FAIL dbz_flag: got %b want 1", dbz); end
      @(posedge clk); #1;
      n_checks++; if (bus.div_by_zero !== 1'b0) begin n_fail++; $display("FAIL dbz_pulse: got %b want 0", bus.div_by_zero); end
      start_op(2'b11, 32'hFFFF_FFF9, 32'd0);
      wait_done(cyc, dbz);
      n_checks++; if (bus.hi !== 32'hFFFF_FFF9) begin n_fail++; $display("FAIL dbz_signed_hi: got %h want fffffff9", bus.hi); end
      n_checks++; if (bus.lo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL dbz_signed_lo: got %h want ffffffff", bus.lo); end
   endtask

   task automatic test_div_wrap();
      int cyc; logic dbz;
      start_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(cyc, dbz);
      n_checks++; if (bus.lo !== 32'h8000_0000) begin n_fail++; $display("FAIL wrap_lo: got %h want 80000000", bus.lo); end
      n_checks++; if (bus.hi !== 32'h0) begin n_fail++; $display("FAIL wrap_hi: got %h want 00000000", bus.hi); end
      n_checks++; if (dbz !== 1'b0) begin n_fail++; $display("FAIL wrap_dbz: got %b want 0", dbz); end
   endtask

   task automatic test_start_ignored();
      int cyc; logic dbz;
      start_op(2'b00, 32'd7, 32'd6);
      repeat (4) begin @(posedge clk); #1; end
      start_op(2'b00, 32'd1, 32'd1);
      wait_done(cyc, dbz);
      n_checks++; if (cyc !== 28) begin n_fail++; $display("FAIL ignore_latency: got %0d want 28", cyc); end
      n_checks++; if (bus.lo !== 32'd42) begin n_fail++; $display("FAIL ignore_lo: got %h want 0000002a", bus.lo); end
      n_checks++; if (bus.hi !== 32'd0) begin n_fail++; $display("FAIL ignore_hi: got %h want 00000000", bus.hi); end
   endtask

   task automatic test_abort();
      int seen;
      start_op(2'b00, 32'd7, 32'd6);
      repeat (4) begin @(posedge clk); #1; end
      start_op(2'b00, 32'd1, 32'd1);
      repeat (4) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
      n_checks++; if (bus.hi !== 32'h0) begin n_fail++; $display("FAIL abort_hi: got %h want 00000000", bus.hi); end
      n_checks++; if (bus.lo !== 32'h0) begin n_fail++; $display("FAIL abort_lo: got %h want 00000000", bus.lo); end
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (bus.done) seen++;
      end
      n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d done pulses want 0", seen); end
      bus.wr_lo = 1'b1;
      bus.wdata = 32'h0000_1234;
      @(posedge clk); #1;
      bus.wr_lo = 1'b0;
      n_checks++; if (bus.lo !== 32'h0000_1234) begin n_fail++; $display("FAIL mtlo_lo: got %h want 00001234", bus.lo); end
      n_checks++; if (bus.hi !== 32'h0) begin n_fail++; $display("FAIL mtlo_hi: got %h want 00000000", bus.hi); end
   endtask

   task automatic test_write_with_start();
      int cyc; logic dbz;
      bus.wr_hi = 1'b1;
      bus.wdata = 32'hCAFE_0001;
      start_op(2'b10, 32'd9, 32'd4);
      bus.wr_hi = 1'b0;
      n_checks++; if (bus.hi !== 32'hCAFE_0001) begin n_fail++; $display("FAIL wstart_hi: got %h want cafe0001", bus.hi); end
      n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL wstart_busy: got %b want 1", bus.busy); end
      wait_done(cyc, dbz);
      n_checks++; if (bus.lo !== 32'd2) begin n_fail++; $display("FAIL wstart_lo: got %h want 00000002", bus.lo); end
      n_checks++; if (bus.hi !== 32'd1) begin n_fail++; $display("FAIL wstart_rem: got %h want 00000001", bus.hi); end
   endtask

   task automatic test_back_to_back();
      int cyc; logic dbz;
      start_op(2'b00, 32'd3, 32'd4);
      wait_done(cyc, dbz);
      n_checks++; if (bus.lo !== 32'd12) begin n_fail++; $display("FAIL b2b_first_lo: got %h want 0000000c", bus.lo); end
      start_op(2'b01, 32'hFFFF_FFFE, 32'hFFFF_FFFE);
      bus.wr_hi = 1'b1;
      bus.wdata = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      bus.wr_hi = 1'b0;
      n_checks++; if (bus.hi !== 32'h0) begin n_fail++; $display("FAIL b2b_mthi_busy: got %h want 00000000", bus.hi); end
      n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy: got %b want 1", bus.busy); end
      wait_done(cyc, dbz);
      n_checks++; if (cyc !== 32) begin n_fail++; $display("FAIL b2b_latency: got %0d want 32", cyc); end
      n_checks++; if (bus.lo !== 32'd4) begin n_fail++; $display("FAIL b2b_second_lo: got %h want 00000004", bus.lo); end
      n_checks++; if (bus.hi !== 32'd0) begin n_fail++; $display("FAIL b2b_second_hi: got %h want 00000000", bus.hi); end
   endtask

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.op    = 2'b00;
      bus.A     = '0;
      bus.B     = '0;
      bus.wr_hi = 1'b0;
      bus.wr_lo = 1'b0;
      bus.wdata = '0;
      test_reset();
      test_multu();
      test_mult();
      test_div();
      test_div_by_zero();
      test_div_wrap();
      test_start_ignored();
      test_abort();
      test_write_with_start();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
